// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end.
// Issues sequential word-aligned fetch requests under a credit limit, queues the
// returned instructions with their PCs in a DEPTH-entry circular FIFO, and
// flushes on redirect, discarding responses that belong to pre-redirect requests.
// Optional feature macro: FETCH_BYPASS_EN -- a response arriving while the queue
// is empty is presented to decode in the same cycle.
module fetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic [31:0] out_pcincre,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] ZERO_C    = {CW{1'b0}};
  localparam logic [CW-1:0] ONE_C     = CW'(1'b1);
  localparam logic [AW-1:0] PTR_ZERO_C = {AW{1'b0}};
  localparam logic [AW-1:0] PTR_ONE_C  = AW'(1'b1);
  localparam logic [CW:0]   DEPTH_C   = (CW+1)'(DEPTH);

  // Architectural state
  logic [31:0]   fetch_pc_r;
  logic [31:0]   rsp_pc_r;       // PC of the next kept response
  logic [CW-1:0] count_r;
  logic [CW-1:0] outstanding_r;
  logic [CW-1:0] drop_r;
  logic [AW-1:0] wptr_r;
  logic [AW-1:0] rptr_r;
  logic [31:0]   inst_mem_r [DEPTH];
  logic [31:0]   pc_mem_r   [DEPTH];

  // Next-state and control
  logic [31:0]   fetch_pc_nxt_s;
  logic [31:0]   rsp_pc_nxt_s;
  logic [CW-1:0] count_nxt_s;
  logic [CW-1:0] outstanding_nxt_s;
  logic [CW-1:0] drop_nxt_s;
  logic [AW-1:0] wptr_nxt_s;
  logic [AW-1:0] rptr_nxt_s;
  logic [31:0]   redirect_base_s;
  logic          credit_ok_s;
  logic          req_valid_s;
  logic          req_fire_s;
  logic          rsp_seen_s;
  logic          rsp_keep_s;
  logic          rsp_drop_s;
  logic          head_valid_s;
  logic          bypass_s;
  logic          has_inst_s;
  logic          push_s;
  logic          pop_s;
  logic          out_valid_s;
  logic [31:0]   out_inst_s;
  logic [31:0]   out_pc_s;
  logic          unused_s;

  // Low address bits of a redirect target are ignored by design
  assign unused_s        = ^redirect_pc[1:0];
  assign redirect_base_s = {redirect_pc[31:2], 2'b00};

  // Credit rule: every in-flight request is guaranteed a queue slot
  assign credit_ok_s  = ({1'b0, count_r} + {1'b0, outstanding_r}) < DEPTH_C;
  assign req_valid_s  = !rst && !halt && !redirect_valid && credit_ok_s;
  assign req_fire_s   = req_valid_s && imem_req_ready;

  // Response classification; a response in a redirect cycle is always discarded
  assign rsp_seen_s   = imem_rsp_valid && (outstanding_r != ZERO_C);
  assign rsp_keep_s   = imem_rsp_valid && !redirect_valid && (drop_r == ZERO_C);
  assign rsp_drop_s   = imem_rsp_valid && !redirect_valid && (drop_r != ZERO_C);
  assign head_valid_s = (count_r != ZERO_C);

`ifdef FETCH_BYPASS_EN
  assign bypass_s = rsp_keep_s && !head_valid_s;
`else
  assign bypass_s = 1'b0;
`endif

  assign has_inst_s = !rst && (head_valid_s || bypass_s);
  assign pop_s      = out_valid_s && out_ready && head_valid_s;
  assign push_s     = rsp_keep_s && !(bypass_s && out_ready);

  // Decode-side view: FIFO head first, else the bypassed response
  always_comb begin
    out_valid_s = 1'b0;
    out_inst_s  = 32'h0000_0000;
    out_pc_s    = 32'h0000_0000;
    if (rst) begin
      out_valid_s = 1'b0;
    end else if (head_valid_s) begin
      out_valid_s = !redirect_valid;
      out_inst_s  = inst_mem_r[rptr_r];
      out_pc_s    = pc_mem_r[rptr_r];
    end else if (bypass_s) begin
      out_valid_s = !redirect_valid;
      out_inst_s  = imem_rsp_data;
      out_pc_s    = rsp_pc_r;
    end else begin
      out_valid_s = 1'b0;
    end
  end

  assign imem_req_valid = req_valid_s;
  assign imem_req_addr  = fetch_pc_r;
  assign out_valid      = out_valid_s;
  assign out_inst       = out_inst_s;
  assign out_pc         = out_pc_s;
  assign out_pcincre    = has_inst_s ? (out_pc_s + 32'd4) : 32'h0000_0000;

  // Next-state: redirect flushes and retargets, otherwise normal flow
  always_comb begin
    fetch_pc_nxt_s = fetch_pc_r;
    rsp_pc_nxt_s   = rsp_pc_r;
    count_nxt_s    = count_r;
    drop_nxt_s     = drop_r;
    wptr_nxt_s     = wptr_r;
    rptr_nxt_s     = rptr_r;
    if (redirect_valid) begin
      fetch_pc_nxt_s = redirect_base_s;
      rsp_pc_nxt_s   = redirect_base_s;
      count_nxt_s    = ZERO_C;
      wptr_nxt_s     = PTR_ZERO_C;
      rptr_nxt_s     = PTR_ZERO_C;
      // Everything still in flight belongs to the old path
      if (rsp_seen_s) begin
        drop_nxt_s = outstanding_r - ONE_C;
      end else begin
        drop_nxt_s = outstanding_r;
      end
    end else begin
      if (req_fire_s) begin
        fetch_pc_nxt_s = fetch_pc_r + 32'd4;
      end else begin
        fetch_pc_nxt_s = fetch_pc_r;
      end
      if (rsp_keep_s) begin
        rsp_pc_nxt_s = rsp_pc_r + 32'd4;
      end else begin
        rsp_pc_nxt_s = rsp_pc_r;
      end
      if (rsp_drop_s) begin
        drop_nxt_s = drop_r - ONE_C;
      end else begin
        drop_nxt_s = drop_r;
      end
      if (push_s) begin
        wptr_nxt_s = wptr_r + PTR_ONE_C;
      end else begin
        wptr_nxt_s = wptr_r;
      end
      if (pop_s) begin
        rptr_nxt_s = rptr_r + PTR_ONE_C;
      end else begin
        rptr_nxt_s = rptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_nxt_s = count_r + ONE_C;
        2'b01:   count_nxt_s = count_r - ONE_C;
        default: count_nxt_s = count_r;
      endcase
    end
  end

  // Outstanding requests: +1 per accepted request, -1 per response of any kind
  always_comb begin
    outstanding_nxt_s = outstanding_r;
    case ({req_fire_s, rsp_seen_s})
      2'b10:   outstanding_nxt_s = outstanding_r + ONE_C;
      2'b01:   outstanding_nxt_s = outstanding_r - ONE_C;
      default: outstanding_nxt_s = outstanding_r;
    endcase
  end

  // Control state registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_r    <= RESET_PC;
      rsp_pc_r      <= RESET_PC;
      count_r       <= ZERO_C;
      outstanding_r <= ZERO_C;
      drop_r        <= ZERO_C;
      wptr_r        <= PTR_ZERO_C;
      rptr_r        <= PTR_ZERO_C;
    end else begin
      fetch_pc_r    <= fetch_pc_nxt_s;
      rsp_pc_r      <= rsp_pc_nxt_s;
      count_r       <= count_nxt_s;
      outstanding_r <= outstanding_nxt_s;
      drop_r        <= drop_nxt_s;
      wptr_r        <= wptr_nxt_s;
      rptr_r        <= rptr_nxt_s;
    end
  end

  // Queue storage; contents are only observed while count is non-zero
  always_ff @(posedge clk) begin
    if (push_s) begin
      inst_mem_r[wptr_r] <= imem_rsp_data;
      pc_mem_r[wptr_r]   <= rsp_pc_r;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit (DEPTH=4, RESET_PC=0).
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = 32'h0;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [31:0] out_pcincre;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef FETCH_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  fetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_pc(out_pc), .out_pcincre(out_pcincre),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt)
  );

  always #5 clk = ~clk;

  // Memory model: in-order, one response per cycle while rsp_en, data = ~addr
  logic [31:0] pend_q[$];
  bit          rsp_en;
  int          req_count = 0;
  always @(posedge clk) begin
    if (rst) req_count = 0;
    else if (imem_req_valid && imem_req_ready) begin
      pend_q.push_back(imem_req_addr);
      req_count++;
    end
    #1;
    if (rst) begin
      pend_q.delete();
      imem_rsp_valid = 1'b0;
    end else if (rsp_en && pend_q.size() > 0) begin
      imem_rsp_data  = ~pend_q.pop_front();
      imem_rsp_valid = 1'b1;
    end else begin
      imem_rsp_valid = 1'b0;
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; halt = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    out_ready = 1'b0; imem_req_ready = 1'b1; rsp_en = 1'b0;
    repeat (3) cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; halt = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    out_ready = 1'b1; imem_req_ready = 1'b1; rsp_en = 1'b1;
    repeat (2) cyc();
    n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid: got %b expected 0", imem_req_valid); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (imem_req_addr !== 32'h0) begin n_fail++; $display("FAIL reset_req_addr: got %h expected 0", imem_req_addr); end
    n_checks++; if (out_inst !== 32'h0 || out_pc !== 32'h0 || out_pcincre !== 32'h0) begin n_fail++; $display("FAIL reset_out_data: got %h/%h/%h expected 0/0/0", out_inst, out_pc, out_pcincre); end
    rst = 1'b0; #1;
    n_checks++; if (imem_req_valid !== 1'b1) begin n_fail++; $display("FAIL reset_release_req: got %b expected 1", imem_req_valid); end
  endtask

  task automatic test_stream();
    logic [31:0] e;
    logic        exp_v;
    apply_reset(); out_ready = 1'b1; rsp_en = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      cyc();
      n_checks++; if (imem_req_addr !== 32'(4*k)) begin n_fail++; $display("FAIL stream_addr[%0d]: got %h expected %h", k, imem_req_addr, 32'(4*k)); end
      exp_v = (k >= LAT);
      n_checks++; if (out_valid !== exp_v) begin n_fail++; $display("FAIL stream_valid[%0d]: got %b expected %b", k, out_valid, exp_v); end
      if (exp_v) begin
        e = 32'(4*(k-LAT));
        n_checks++; if (out_pc !== e || out_inst !== ~e || out_pcincre !== e + 32'd4) begin n_fail++; $display("FAIL stream_out[%0d]: got pc %h inst %h inc %h expected pc %h", k, out_pc, out_inst, out_pcincre, e); end
      end
    end
  endtask

  task automatic test_backpressure();
    apply_reset(); out_ready = 1'b0; rsp_en = 1'b1;
    repeat (8) cyc();
    n_checks++; if (req_count !== 4) begin n_fail++; $display("FAIL bp_req_count: got %0d expected 4", req_count); end
    n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL bp_req_stall: got %b expected 0", imem_req_valid); end
    n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin n_fail++; $display("FAIL bp_head: got v%b pc %h expected v1 pc 0", out_valid, out_pc); end
    out_ready = 1'b1;
    cyc();
    n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h10) begin n_fail++; $display("FAIL bp_resume: got v%b addr %h expected v1 addr 10", imem_req_valid, imem_req_addr); end
    n_checks++; if (out_pc !== 32'h4) begin n_fail++; $display("FAIL bp_next_head: got %h expected 4", out_pc); end
  endtask

  task automatic test_redirect();
    int got;
    logic [31:0] e;
    apply_reset(); out_ready = 1'b1; rsp_en = 1'b0;
    repeat (3) cyc();
    n_checks++; if (imem_req_addr !== 32'hC) begin n_fail++; $display("FAIL redir_pre_addr: got %h expected c", imem_req_addr); end
    redirect_valid = 1'b1; redirect_pc = 32'h103; rsp_en = 1'b1; #1;
    n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL redir_req_block: got %b expected 0", imem_req_valid); end
    cyc();
    redirect_valid = 1'b0; #1;
    n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin n_fail++; $display("FAIL redir_addr: got v%b addr %h expected v1 addr 100", imem_req_valid, imem_req_addr); end
    got = 0;
    for (int i = 0; i < 15 && got < 3; i++) begin
      cyc();
      if (out_valid === 1'b1) begin
        e = 32'h100 + 32'(4*got);
        n_checks++; if (out_pc !== e || out_inst !== ~e) begin n_fail++; $display("FAIL redir_out[%0d]: got pc %h inst %h expected pc %h", got, out_pc, out_inst, e); end
        got++;
      end
    end
    n_checks++; if (got !== 3) begin n_fail++; $display("FAIL redir_out_count: got %0d expected 3", got); end
  endtask

  task automatic test_halt();
    int got;
    int bad;
    apply_reset(); out_ready = 1'b1; rsp_en = 1'b0;
    repeat (2) cyc();
    halt = 1'b1; rsp_en = 1'b1; #1;
    n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL halt_req_block: got %b expected 0", imem_req_valid); end
    got = 0; bad = 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (imem_req_valid !== 1'b0) bad++;
      if (out_valid === 1'b1) begin
        n_checks++; if (out_pc !== 32'(4*got)) begin n_fail++; $display("FAIL halt_out[%0d]: got %h expected %h", got, out_pc, 32'(4*got)); end
        got++;
      end
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL halt_req_seen: got %0d cycles expected 0", bad); end
    n_checks++; if (got !== 2) begin n_fail++; $display("FAIL halt_out_count: got %0d expected 2", got); end
    halt = 1'b0; #1;
    n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8) begin n_fail++; $display("FAIL halt_resume: got v%b addr %h expected v1 addr 8", imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_redirect_pop();
    int got;
    apply_reset(); out_ready = 1'b0; rsp_en = 1'b1;
    repeat (3) cyc();
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rpop_pre_valid: got %b expected 1", out_valid); end
    out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h200; #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rpop_forced_low: got %b expected 0", out_valid); end
    cyc();
    redirect_valid = 1'b0; #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rpop_empty: got %b expected 0", out_valid); end
    n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin n_fail++; $display("FAIL rpop_addr: got v%b addr %h expected v1 addr 200", imem_req_valid, imem_req_addr); end
    got = 0;
    for (int i = 0; i < 10 && got < 1; i++) begin
      cyc();
      if (out_valid === 1'b1) begin
        n_checks++; if (out_pc !== 32'h200) begin n_fail++; $display("FAIL rpop_first_out: got %h expected 200", out_pc); end
        got++;
      end
    end
    n_checks++; if (got !== 1) begin n_fail++; $display("FAIL rpop_timeout: got %0d outputs expected 1", got); end
  endtask

  task automatic test_back_to_back();
    apply_reset(); out_ready = 1'b1; rsp_en = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h300;
    cyc();
    n_checks++; if (imem_req_valid !== 1'b0 || imem_req_addr !== 32'h300) begin n_fail++; $display("FAIL b2b_first: got v%b addr %h expected v0 addr 300", imem_req_valid, imem_req_addr); end
    redirect_pc = 32'h406;
    cyc();
    redirect_valid = 1'b0; #1;
    n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h404) begin n_fail++; $display("FAIL b2b_second: got v%b addr %h expected v1 addr 404", imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_wrap();
    int got;
    logic [31:0] exp_pc [2];
    logic [31:0] exp_inc [2];
    exp_pc[0] = 32'hFFFF_FFFC; exp_inc[0] = 32'h0000_0000;
    exp_pc[1] = 32'h0000_0000; exp_inc[1] = 32'h0000_0004;
    apply_reset(); out_ready = 1'b1; rsp_en = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    cyc();
    redirect_valid = 1'b0; #1;
    n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_addr0: got v%b addr %h expected v1 addr fffffffc", imem_req_valid, imem_req_addr); end
    cyc();
    n_checks++; if (imem_req_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_addr1: got %h expected 0", imem_req_addr); end
    got = 0;
    for (int i = 0; i < 10 && got < 2; i++) begin
      if (out_valid === 1'b1) begin
        n_checks++; if (out_pc !== exp_pc[got] || out_pcincre !== exp_inc[got]) begin n_fail++; $display("FAIL wrap_out[%0d]: got pc %h inc %h expected pc %h inc %h", got, out_pc, out_pcincre, exp_pc[got], exp_inc[got]); end
        got++;
      end
      cyc();
    end
    n_checks++; if (got !== 2) begin n_fail++; $display("FAIL wrap_out_count: got %0d expected 2", got); end
  endtask

  task automatic test_reset_mid();
    int got;
    apply_reset(); out_ready = 1'b0; rsp_en = 1'b1;
    repeat (3) cyc();
    rst = 1'b1; #1;
    n_checks++; if (out_valid !== 1'b0 || imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valids: got out %b req %b expected 0 0", out_valid, imem_req_valid); end
    n_checks++; if (imem_req_addr !== 32'h0 || out_pc !== 32'h0 || out_pcincre !== 32'h0) begin n_fail++; $display("FAIL midrst_data: got addr %h pc %h inc %h expected 0 0 0", imem_req_addr, out_pc, out_pcincre); end
    repeat (2) cyc();
    rst = 1'b0; out_ready = 1'b1;
    got = 0;
    for (int i = 0; i < 10 && got < 1; i++) begin
      cyc();
      if (out_valid === 1'b1) begin
        n_checks++; if (out_pc !== 32'h0) begin n_fail++; $display("FAIL midrst_first_out: got %h expected 0", out_pc); end
        got++;
      end
    end
    n_checks++; if (got !== 1) begin n_fail++; $display("FAIL midrst_timeout: got %0d outputs expected 1", got); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_halt();
    test_redirect_pop();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 4, instruction queue entries and maximum outstanding requests (legal 2..16, power of two).
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port imem_req_valid  output  1  fetch request valid.
REQ-006 SHALL have port imem_req_ready  input  1  memory accepts request.
REQ-007 SHALL have port imem_req_addr  output  32  fetch address, word aligned.
REQ-008 SHALL have port imem_rsp_valid  input  1  response valid, in request order, no backpressure.
REQ-009 SHALL have port imem_rsp_data  input  32  returned instruction.
REQ-010 SHALL have port out_valid  output  1  instruction available to decode.
REQ-011 SHALL have port out_ready  input  1  decode consumes instruction.
REQ-012 SHALL have port out_inst  output  32  instruction.
REQ-013 SHALL have port out_pc  output  32  address of out_inst.
REQ-014 SHALL have port out_pcincre  output  32  out_pc + 4.
REQ-015 SHALL have port redirect_valid  input  1  branch/jump taken, flush.
REQ-016 SHALL have port redirect_pc  input  32  new fetch address; bits [1:0] ignored (treated 0).
REQ-017 SHALL have port halt  input  1  level; suppress new requests while high.

Function
REQ-018 SHALL hold fetch_pc; a request transfers when imem_req_valid and imem_req_ready are both high; fetch_pc then advances by 4 (32-bit wrap, 32'hFFFF_FFFC -> 0).
REQ-019 SHALL assert imem_req_valid only when !halt, !redirect_valid, and queue_count + outstanding < DEPTH (credit rule; guarantees space for every response).
REQ-020 SHALL store each accepted response with its PC into a circular FIFO of DEPTH entries; read/write pointers wrap modulo DEPTH.
REQ-021 SHALL drive out_valid = (queue_count != 0) && !redirect_valid; out_inst/out_pc/out_pcincre from FIFO head.
REQ-022 SHALL pop the head when out_valid && out_ready; simultaneous push and pop keeps count unchanged.
REQ-023 On redirect_valid: SHALL empty FIFO, set fetch_pc = {redirect_pc[31:2],2'b00} next cycle, and load drop_count with outstanding requests (excluding any response arriving that cycle, which is also discarded).
REQ-024 SHALL discard responses while drop_count != 0, decrementing per response; a request accepted after redirect is never discarded.
REQ-025 Redirect asserted in consecutive cycles SHALL each apply; latest redirect_pc wins.
REQ-026 Halt SHALL not flush: outstanding responses still enqueue and queue drains normally; deassert resumes at fetch_pc.
REQ-027 Default latency: response in cycle N -> out_valid in cycle N+1.

Reset
REQ-028 While rst high: fetch_pc = RESET_PC, queue_count = 0, outstanding = 0, drop_count = 0, pointers = 0.
REQ-029 Outputs during reset SHALL be imem_req_valid = 0, out_valid = 0, imem_req_addr = RESET_PC; out_inst/out_pc/out_pcincre = 0.
REQ-030 Reset mid-transaction SHALL abandon in-flight requests; memory side is reset together, no late response expected.

Configuration
REQ-031 Macro FETCH_BYPASS_EN: when defined, a response arriving while queue empty (and not dropped) SHALL drive out_valid/out_inst/out_pc combinationally the same cycle; if out_ready is high it is consumed and not enqueued, else enqueued.
REQ-032 Without FETCH_BYPASS_EN: no combinational path imem_rsp_* -> out_*; latency per REQ-027.

Verification
REQ-033 Reset release, DEPTH=4, memory ready always, 1-cycle response, out_ready=1 -> out_pc sequence 0x0,0x4,0x8,0xC on consecutive cycles from cycle 2 (cycle 1 with bypass).
REQ-034 out_ready=0 held -> exactly 4 requests issued (0x0..0xC), imem_req_valid low afterwards; out_ready=1 -> 0x0 popped, request 0x10 issued next cycle.
REQ-035 Redirect to 0x103 with 3 requests outstanding -> next imem_req_addr 0x100, the 3 stale responses dropped, first out_pc 0x100.
REQ-036 halt=1 with 2 outstanding -> no new requests, both responses delivered 0x0,0x4; halt=0 -> request 0x8.
REQ-037 redirect_valid and out_valid&&out_ready same cycle -> out_valid forced 0, no pop counted, FIFO empty next cycle.
REQ-038 Redirect to 0xFFFF_FFFC -> fetch addresses 0xFFFF_FFFC then 0x0000_0000.
